sum_uart_tx: RTL and testbench

Serial output stage placed directly downstream of the 8-bit operand adder. Accepts each 8-bit sum over a valid/ready handshake and transmits it on a single pin as an asynchronous-serial frame: start bit, 8 data bits LSB first, optional even parity, one stop bit. The chip can therefore report results over one `uo_out` pin, which frees the remaining outputs.

---
 rtl/sum_uart_pkg.sv | 16 +
 rtl/sum_uart_tx_if.sv | 12 +
 rtl/uart_bit_timer.sv | 25 ++
 rtl/sum_uart_tx.sv | 107 ++++++++++
 tb/tb_sum_uart_tx.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sum_uart_pkg.sv
// Shared definitions for the sum UART transmitter: FSM state type and
// framing constants used by the top level and its interface.
package sum_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int   FRAME_DATA_BITS = 8;
    localparam logic TX_IDLE_LEVEL   = 1'b1;

endpackage

// File: rtl/sum_uart_tx_if.sv
// Valid/ready handshake carrying one adder sum into the transmitter.
interface sum_uart_tx_if;
    import sum_uart_pkg::*;

    logic [FRAME_DATA_BITS-1:0] in_data;
    logic                       in_valid;
    logic                       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/uart_bit_timer.sv
// Free-running bit-period counter; expire marks the last cycle of a bit.
module uart_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic expire
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt;

    assign expire = (cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Count 0..CLKS_PER_BIT-1 and wrap; held at zero while cleared.
    always_ff @(posedge clk) begin
        if (rst || clear || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sum_uart_tx.sv
// Serial output stage for the operand adder: accepts each 8-bit sum over
// valid/ready and sends start, 8 data bits LSB first, optional even parity
// and one stop bit on tx. At chip level in_data is the adder sum, in_valid
// is the ui_in strobe bit and tx drives uo_out[0].
module sum_uart_tx
    import sum_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int          PARITY_EN    = 0
) (
    input  logic         clk,
    input  logic         rst,
    sum_uart_tx_if.slave in_if,
    output logic         tx,
    output logic         busy,
    output logic         frame_done
);
    uart_state_t                state, state_next;
    logic [FRAME_DATA_BITS-1:0] shift, shift_next;
    logic [2:0]                 idx, idx_next;
    logic                       parity, parity_next;
    logic                       tx_next, busy_next, done_next;
    logic                       expire;

    // Ready is a pure decode of the state register, masked by reset.
    assign in_if.in_ready = (state == IDLE) && !rst;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state == IDLE),
        .expire (expire)
    );

    // Next-state and next-output decode; outputs are derived from the next
    // state so tx/busy/frame_done can be registered without extra latency.
    always_comb begin
        state_next  = state;
        shift_next  = shift;
        idx_next    = idx;
        parity_next = parity;
        done_next   = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_if.in_valid && in_if.in_ready) begin
                    state_next  = START;
                    shift_next  = in_if.in_data;
                    parity_next = ^in_if.in_data;
                    idx_next    = '0;
                end
            end
            START: begin
                if (expire) state_next = DATA;
            end
            DATA: begin
                if (expire) begin
                    shift_next = shift >> 1;
                    idx_next   = idx + 3'd1;
                    if (idx == 3'(FRAME_DATA_BITS - 1)) begin
                        state_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (expire) state_next = STOP;
            end
            STOP: begin
                if (expire) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        tx_next = TX_IDLE_LEVEL;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = parity_next;
            default: tx_next = TX_IDLE_LEVEL;
        endcase
        busy_next = (state_next != IDLE);
    end

    // State, datapath and registered outputs; reset aborts any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shift      <= '0;
            idx        <= '0;
            parity     <= 1'b0;
            tx         <= TX_IDLE_LEVEL;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            shift      <= shift_next;
            idx        <= idx_next;
            parity     <= parity_next;
            tx         <= tx_next;
            busy       <= busy_next;
            frame_done <= done_next;
        end
    end

endmodule

// File: tb/tb_sum_uart_tx.sv
// Bench for sum_uart_tx: three instances (C=4 8N1, C=4 8E1, C=1 8N1) checked
// every cycle against a frame-level model, plus literal expectations.
module tb_sum_uart_tx;

    localparam int NDUT = 3;
    localparam int HIST = 1024;
    localparam int CP [NDUT] = '{4, 4, 1};
    localparam int PE [NDUT] = '{0, 1, 0};
    localparam int A5_SEQ [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    logic       clk;
    logic       rst;
    logic       vld   [NDUT];
    logic [7:0] dat   [NDUT];
    logic       tx_w  [NDUT];
    logic       busy_w[NDUT];
    logic       done_w[NDUT];
    logic       rdy_w [NDUT];

    int checks;
    int errors;
    int cyc_n;
    bit chk_en;

    logic tx_hist  [NDUT][HIST];
    logic done_hist[NDUT][HIST];
    logic rdy_hist [NDUT][HIST];

    // model state: frame in flight, position within frame, frame bits
    logic        m_act [NDUT];
    int          m_pos [NDUT];
    logic [10:0] m_bits[NDUT];
    logic        m_done[NDUT];

    sum_uart_tx_if ifa ();
    sum_uart_tx_if ifb ();
    sum_uart_tx_if ifc ();

    assign ifa.in_valid = vld[0];
    assign ifa.in_data  = dat[0];
    assign rdy_w[0]     = ifa.in_ready;
    assign ifb.in_valid = vld[1];
    assign ifb.in_data  = dat[1];
    assign rdy_w[1]     = ifb.in_ready;
    assign ifc.in_valid = vld[2];
    assign ifc.in_data  = dat[2];
    assign rdy_w[2]     = ifc.in_ready;

    sum_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0)) dut_a (
        .clk(clk), .rst(rst), .in_if(ifa.slave),
        .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]));
    sum_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1)) dut_b (
        .clk(clk), .rst(rst), .in_if(ifb.slave),
        .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]));
    sum_uart_tx #(.CLKS_PER_BIT(1), .PARITY_EN(0)) dut_c (
        .clk(clk), .rst(rst), .in_if(ifc.slave),
        .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(done_w[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [10:0] frame_bits(logic [7:0] v, int p);
        logic [10:0] b;
        b       = '1;
        b[0]    = 1'b0;
        b[8:1]  = v;
        if (p != 0) b[9] = ^v;
        return b;
    endfunction

    function automatic int frame_len(int d);
        return (10 + PE[d]) * CP[d];
    endfunction

    // Frame-level reference: a handshake starts a frame of F cycles, the
    // cycle after it ends carries frame_done; reset drops everything.
    always @(posedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (rst) begin
                m_act[d]  <= 1'b0;
                m_done[d] <= 1'b0;
                m_pos[d]  <= 0;
            end else if (!m_act[d]) begin
                m_done[d] <= 1'b0;
                if (vld[d]) begin
                    m_act[d]  <= 1'b1;
                    m_pos[d]  <= 0;
                    m_bits[d] <= frame_bits(dat[d], PE[d]);
                end
            end else if (m_pos[d] == frame_len(d) - 1) begin
                m_act[d]  <= 1'b0;
                m_done[d] <= 1'b1;
            end else begin
                m_pos[d]  <= m_pos[d] + 1;
                m_done[d] <= 1'b0;
            end
        end
    end

    task automatic check_bit(string name, int d, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %b expected %b", name, d, cyc_n, act, exp);
        end
    endtask

    task automatic checkv(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_all();
        logic exp_tx;
        for (int d = 0; d < NDUT; d++) begin
            exp_tx = m_act[d] ? m_bits[d][m_pos[d] / CP[d]] : 1'b1;
            check_bit("tx", d, tx_w[d], exp_tx);
            check_bit("busy", d, busy_w[d], m_act[d]);
            check_bit("frame_done", d, done_w[d], m_done[d]);
            check_bit("in_ready", d, rdy_w[d], !m_act[d] && !rst);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        if (cyc_n < HIST) begin
            for (int d = 0; d < NDUT; d++) begin
                tx_hist[d][cyc_n]   = tx_w[d];
                done_hist[d][cyc_n] = done_w[d];
                rdy_hist[d][cyc_n]  = rdy_w[d];
            end
        end
        if (chk_en) compare_all();
    endtask

    task automatic idle(int n);
        repeat (n) cyc();
    endtask

    task automatic send(int d, logic [7:0] v, output int t);
        vld[d] = 1'b1;
        dat[d] = v;
        t      = cyc_n;
        cyc();
        vld[d] = 1'b0;
    endtask

    function automatic int first_done(int d, int a, int b);
        for (int c = a; c <= b && c < HIST; c++) begin
            if (done_hist[d][c] === 1'b1) return c;
        end
        return -1;
    endfunction

    function automatic int hist_tx(int d, int c);
        if (c < 0 || c >= HIST) return -1;
        return (tx_hist[d][c] === 1'b1) ? 1 : ((tx_hist[d][c] === 1'b0) ? 0 : -1);
    endfunction

    function automatic int hist_rdy(int d, int c);
        if (c < 0 || c >= HIST) return -1;
        return (rdy_hist[d][c] === 1'b1) ? 1 : 0;
    endfunction

    // Directed scenarios; every cycle is also checked against the model.
    initial begin
        int t, t1, t2, n;
        logic [7:0] v;
        checks = 0;
        errors = 0;
        cyc_n  = 0;
        chk_en = 1'b0;
        rst    = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            vld[d] = 1'b0;
            dat[d] = 8'h00;
        end

        // reset, then 20 idle cycles
        cyc();
        chk_en = 1'b1;
        cyc();
        rst = 1'b0;
        idle(20);
        checkv("idle_ready", hist_rdy(0, cyc_n), 1);
        checkv("idle_tx", hist_tx(2, cyc_n), 1);

        // 0xA5, C=4, 8N1
        send(0, 8'hA5, t);
        idle(50);
        for (int k = 0; k < 10; k++) begin
            checkv($sformatf("a5_bit%0d", k), hist_tx(0, t + 1 + k * 4), A5_SEQ[k]);
        end
        checkv("a5_done_latency", first_done(0, t + 1, t + 60) - t, 41);

        // parity: 0x07 -> 1, 0x03 -> 0, frame of 44 cycles
        send(1, 8'h07, t);
        idle(50);
        checkv("par07_bit", hist_tx(1, t + 1 + 9 * 4), 1);
        checkv("par07_len", first_done(1, t + 1, t + 60) - t - 1, 44);
        send(1, 8'h03, t);
        idle(50);
        checkv("par03_bit", hist_tx(1, t + 1 + 9 * 4), 0);
        checkv("par03_stop", hist_tx(1, t + 1 + 10 * 4), 1);

        // C=1 back-to-back with valid held high
        vld[2] = 1'b1;
        dat[2] = 8'h01;
        t1     = cyc_n;
        t2     = -1;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (cyc_n == t1 + 1) dat[2] = 8'hFF;
            if (t2 < 0 && hist_rdy(2, cyc_n) == 1) t2 = cyc_n;
            else if (t2 >= 0) vld[2] = 1'b0;
        end
        vld[2] = 1'b0;
        checkv("c1_spacing", t2 - t1, 11);
        checkv("c1_done_at_hs", (t2 >= 0 && done_hist[2][t2] === 1'b1) ? 1 : 0, 1);
        checkv("c1_start_next", hist_tx(2, t2 + 1), 0);
        checkv("c1_ff_bit0", hist_tx(2, t2 + 2), 1);

        // reset pulse during data bit 3
        send(0, 8'h5A, t);
        while (cyc_n < t + 18) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        checkv("rst_tx_high", hist_tx(0, t + 19), 1);
        checkv("rst_ready_low", hist_rdy(0, t + 19), 0);
        checkv("rst_ready_after", hist_rdy(0, t + 20), 1);
        idle(50);
        checkv("rst_no_done", first_done(0, t + 1, t + 70), -1);
        send(0, 8'h3C, t);
        idle(50);
        v = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            checkv($sformatf("post_rst_bit%0d", i), hist_tx(0, t + 1 + (i + 1) * 4), int'(v[i]));
        end

        // in_data churns during the frame
        vld[0] = 1'b1;
        dat[0] = 8'hC3;
        t      = cyc_n;
        cyc();
        vld[0] = 1'b0;
        for (int i = 0; i < 50; i++) begin
            dat[0] = 8'($urandom);
            cyc();
        end
        v = 8'hC3;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (hist_tx(0, t + 1 + (i + 1) * 4) == int'(v[i])) n++;
        end
        checkv("churn_bits_match", n, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
